// File: rtl/store_buffer.sv
// store_buffer: in-order posted-store queue between MEM and the data-memory port, with load-hazard detection
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    input  logic [31:0]            st_addr,
    input  logic [31:0]            st_wdata,
    input  logic [3:0]             st_be,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [31:0]            ld_addr,
    input  logic [3:0]             ld_be,
    output logic                   ld_hazard,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    input  logic                   mem_ack,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic {EMPTY, DRAIN} state_t;
    state_t state, state_nx;
    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0] be_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DEPTH-1:0] hit;
    logic push, pop;
    logic unused_lo;
    assign unused_lo = ^ld_addr[1:0];
    assign st_ready = count < (PW+1)'(DEPTH);
    assign push = st_valid & st_ready & |st_be;
    assign pop = mem_req & mem_ack;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else state <= state_nx;
    always_comb
        state_nx = state == EMPTY ? (push ? DRAIN : EMPTY)
                 : (pop && !push && count == (PW+1)'(1) ? EMPTY : DRAIN);
    // mem_* are forced to zero outside DRAIN so reset clears the port at once
    always_comb begin
        mem_req = state == DRAIN;
        empty = state == EMPTY;
        mem_addr = mem_req ? {addr_q[rd_ptr], 2'b00} : '0;
        mem_wdata = mem_req ? data_q[rd_ptr] : '0;
        mem_be = mem_req ? be_q[rd_ptr] : '0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    always_ff @(posedge clk)
        if (push) begin
            addr_q[wr_ptr] <= st_addr[31:2];
            data_q[wr_ptr] <= st_wdata << {st_addr[1:0], 3'b000};
            be_q[wr_ptr] <= st_be;
        end
    // an entry is live when its distance from the head is below count
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        logic [PW-1:0] off;
        assign off = PW'(g) - rd_ptr;
        assign hit[g] = ({1'b0, off} < count) && addr_q[g] == ld_addr[31:2] && |(be_q[g] & ld_be);
    end
    assign ld_hazard = ld_valid & |hit;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table vectors, corner sequences and random traffic against a queue model
module tb_store_buffer;
    localparam int DEPTH = 4;
    logic clk, rst_n;
    logic st_valid, st_ready, ld_valid, ld_hazard, mem_req, mem_ack, empty;
    logic [31:0] st_addr, st_wdata, ld_addr, mem_addr, mem_wdata;
    logic [3:0] st_be, ld_be, mem_be;
    logic [$clog2(DEPTH):0] count;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic sv; logic [31:0] sa; logic [31:0] sd; logic [3:0] sbe;
        logic lv; logic [31:0] la; logic [3:0] lbe; logic ack;
        logic req; logic [31:0] maddr; logic [31:0] mdata; logic [3:0] mbe;
        logic [31:0] cnt; logic haz;
    } vec_t;
    vec_t tv[12];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be), .ld_hazard(ld_hazard),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
        end
    endfunction

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] sbe,
                         input logic lv, input logic [31:0] la, input logic [3:0] lbe, input logic ack);
        st_valid = sv; st_addr = sa; st_wdata = sd; st_be = sbe;
        ld_valid = lv; ld_addr = la; ld_be = lbe; mem_ack = ack;
    endtask

    // compare every output with the queue model, then settle
    task automatic settle_check();
        logic haz;
        logic req;
        #1;
        req = q.size() != 0;
        haz = 1'b0;
        foreach (q[i]) if (q[i].wa == ld_addr[31:2] && (q[i].be & ld_be) != 4'b0) haz = 1'b1;
        chk("mdl_req", {31'b0, mem_req}, {31'b0, req});
        chk("mdl_count", 32'(count), 32'(q.size()));
        chk("mdl_ready", {31'b0, st_ready}, {31'b0, q.size() < DEPTH});
        chk("mdl_empty", {31'b0, empty}, {31'b0, !req});
        chk("mdl_addr", mem_addr, req ? {q[0].wa, 2'b00} : 32'h0);
        chk("mdl_wdata", mem_wdata, req ? q[0].data : 32'h0);
        chk("mdl_be", {28'b0, mem_be}, req ? {28'b0, q[0].be} : 32'h0);
        chk("mdl_hazard", {31'b0, ld_hazard}, {31'b0, haz & ld_valid});
    endtask

    task automatic edge_update();
        logic rdy;
        @(posedge clk);
        rdy = q.size() < DEPTH;
        if (q.size() > 0 && mem_ack) void'(q.pop_front());
        if (st_valid && rdy && st_be != 4'b0)
            q.push_back('{st_addr[31:2], st_wdata << (8 * st_addr[1:0]), st_be});
        #1;
    endtask

    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] sbe,
                         input logic lv, input logic [31:0] la, input logic [3:0] lbe, input logic ack);
        drive(sv, sa, sd, sbe, lv, la, lbe, ack);
        settle_check();
        edge_update();
    endtask

    initial begin
        logic [31:0] fill_addr[4];
        tv[0]  = '{1, 32'h1003, 32'h000000AB, 4'b1000, 0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0};
        tv[1]  = '{0, 32'h0, 32'h0, 4'h0, 1, 32'h1000, 4'b1000, 0, 1, 32'h1000, 32'hAB000000, 4'b1000, 1, 1};
        tv[2]  = '{0, 32'h0, 32'h0, 4'h0, 1, 32'h1000, 4'b0111, 1, 1, 32'h1000, 32'hAB000000, 4'b1000, 1, 0};
        tv[3]  = '{1, 32'h3000, 32'h55, 4'b0000, 0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0};
        tv[4]  = '{0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0};
        tv[5]  = '{1, 32'h2002, 32'h00001234, 4'b1100, 0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0};
        tv[6]  = '{0, 32'h0, 32'h0, 4'h0, 1, 32'h2000, 4'b0011, 0, 1, 32'h2000, 32'h12340000, 4'b1100, 1, 0};
        tv[7]  = '{0, 32'h0, 32'h0, 4'h0, 1, 32'h2000, 4'b1111, 1, 1, 32'h2000, 32'h12340000, 4'b1100, 1, 1};
        tv[8]  = '{0, 32'h0, 32'h0, 4'h0, 1, 32'h2000, 4'b1111, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0};
        tv[9]  = '{1, 32'h2004, 32'hDEADBEEF, 4'b1111, 1, 32'h2004, 4'b1111, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0};
        tv[10] = '{0, 32'h0, 32'h0, 4'h0, 1, 32'h2004, 4'b1111, 1, 1, 32'h2004, 32'hDEADBEEF, 4'b1111, 1, 1};
        tv[11] = '{0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0};
        fill_addr = '{32'h100, 32'h204, 32'h308, 32'h40c};
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", {31'b0, empty}, 32'h1);
        chk("rst_ready", {31'b0, st_ready}, 32'h1);
        chk("rst_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].sv, tv[i].sa, tv[i].sd, tv[i].sbe, tv[i].lv, tv[i].la, tv[i].lbe, tv[i].ack);
            settle_check();
            chk($sformatf("tv%0d_req", i), {31'b0, mem_req}, {31'b0, tv[i].req});
            chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].maddr);
            chk($sformatf("tv%0d_wdata", i), mem_wdata, tv[i].mdata);
            chk($sformatf("tv%0d_be", i), {28'b0, mem_be}, {28'b0, tv[i].mbe});
            chk($sformatf("tv%0d_count", i), 32'(count), tv[i].cnt);
            chk($sformatf("tv%0d_hazard", i), {31'b0, ld_hazard}, {31'b0, tv[i].haz});
            edge_update();
        end
        // fill to DEPTH with no ack, refuse a fifth, then drain in order
        for (int i = 0; i < 4; i++) cycle(1, fill_addr[i], 32'(i + 1), 4'hF, 0, 0, 0, 0);
        drive(1, 32'h500, 32'h5, 4'hF, 0, 0, 0, 0);
        settle_check();
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", {31'b0, st_ready}, 32'h0);
        edge_update();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        settle_check();
        chk("full_count_hold", 32'(count), 32'd4);
        edge_update();
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            settle_check();
            if (i == 1) chk("after_ack_ready", {31'b0, st_ready}, 32'h1);
            chk($sformatf("drain%0d_addr", i), mem_addr, fill_addr[i]);
            chk($sformatf("drain%0d_wdata", i), mem_wdata, 32'(i + 1));
            edge_update();
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        // full buffer: push plus ack in one cycle refuses the push
        for (int i = 0; i < 4; i++) cycle(1, 32'h600 + 32'(4 * i), 32'(i), 4'hF, 0, 0, 0, 0);
        cycle(1, 32'h6F0, 32'h99, 4'hF, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        settle_check();
        chk("full_pushpop_count", 32'(count), 32'd3);
        edge_update();
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h700 + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, 1);
            settle_check();
            chk($sformatf("stream%0d_count", i), 32'(count), 32'd2);
            edge_update();
        end
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1);
        chk("stream_empty", {31'b0, empty}, 32'h1);
        // async reset with three pending entries
        for (int i = 0; i < 3; i++) cycle(1, 32'h800 + 32'(4 * i), 32'h11 * 32'(i + 1), 4'hF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h800, 4'hF, 0);
        #1;
        chk("pre_rst_hazard", {31'b0, ld_hazard}, 32'h1);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_req", {31'b0, mem_req}, 32'h0);
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_hazard", {31'b0, ld_hazard}, 32'h0);
        chk("arst_empty", {31'b0, empty}, 32'h1);
        chk("arst_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 32'h0000_9001, 32'h0000_00CD, 4'b0010, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        settle_check();
        chk("post_rst_addr", mem_addr, 32'h9000);
        chk("post_rst_wdata", mem_wdata, 32'h0000CD00);
        chk("post_rst_be", {28'b0, mem_be}, 32'h2);
        edge_update();
        // random traffic over a few words to exercise hazards and wrap
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 32'h800 + 32'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, 32'h800 + 32'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
